cpu_trace_serializer: RTL and testbench
=======================================

CPU_TRACE_SERIALIZER -- requirements
Module: cpu_trace_serializer

Interface
REQ-001 SHALL use `clk  in  1`: rising-edge clock for all state.
REQ-002 SHALL use `reset  in  1`: synchronous, active-high reset.
REQ-003 SHALL use `in_valid  in  1`: a trace record is present on the in_* inputs.
REQ-004 SHALL use `in_ready  out  1`: the serializer can accept a record this cycle.
REQ-005 SHALL use `in_kind  in  1`: record type; 0 = register write (`$`), 1 = memory write (`*`).
REQ-006 SHALL use `in_time  in  16`: time as 4 BCD digits, most significant nibble first.
REQ-007 SHALL use `in_pc  in  32`: instruction address.
REQ-008 SHALL use `in_grf  in  5`: register number; used only when in_kind = 0.
REQ-009 SHALL use `in_addr  in  32`: memory address; used only when in_kind = 1.
REQ-010 SHALL use `in_data  in  32`: written data.
REQ-011 SHALL use `char_out  out  8`: ASCII character stream, one character per cycle, feeding the cpu_checker char input.
REQ-012 SHALL use `char_valid  out  1`: char_out carries a line character.

Function
REQ-013 SHALL accept a record at a rising edge where in_valid and in_ready are both high; the serializer registers all in_* fields at that edge.
REQ-014 SHALL assert in_ready only in the IDLE state and in the HASH state.
REQ-015 SHALL put the `^` of the accepted record on char_out in the cycle after acceptance; char_out and char_valid are driven from registered state only.
REQ-016 SHALL emit the line as `^ TIME @ PC : TAG OPER < = DATA #`, one character per cycle, with no gap cycles inside a line.
REQ-017 SHALL emit TIME as decimal digits with leading zeros suppressed, and SHALL emit at least one digit (time 0 gives `0`).
REQ-018 SHALL emit a BCD nibble greater than 9 as `X` (0x58).
REQ-019 SHALL emit PC, the memory address and DATA as exactly 8 lowercase hex digits, most significant first.
REQ-020 SHALL emit TAG/OPER as `$` followed by in_grf in decimal (1 or 2 digits, no leading zero) when in_kind = 0.
REQ-021 SHALL emit TAG/OPER as `*` followed by in_addr in hex (8 digits) when in_kind = 1.
REQ-022 SHALL use the states IDLE, CARET, TIME, AT, PC, COLON, TAG, OPER, LT, EQ, DATA, HASH, plus SP states when SERIALIZER_SPACE_EN is defined.
REQ-023 SHALL go from HASH to CARET when a record is accepted in the HASH cycle, otherwise to IDLE.
REQ-024 SHALL drive char_out = 0x00 and char_valid = 0 in IDLE.
REQ-025 SHALL track digit position with a 3-bit counter; the counter wraps to 0 on each field change.

Reset
REQ-026 SHALL, while reset is high, set state = IDLE, char_out = 0x00, char_valid = 0, in_ready = 1, and clear the digit counter and all field registers.
REQ-027 SHALL, on reset mid-line, abandon the line: the next cycle has char_valid = 0, and the partial line is not resumed.
REQ-028 SHALL give reset priority over in_valid in the same cycle; that record is not accepted.

Configuration
REQ-029 SHALL, with SERIALIZER_SPACE_EN defined, emit one space (0x20) after `:`, one space before `<`, and one space after `=`.
REQ-030 SHALL, without SERIALIZER_SPACE_EN, emit no spaces anywhere in the line.

Structure
REQ-031 SHALL place the ASCII character constants, the state enumeration and the in_kind encoding in shared package cpu_trace_pkg.
REQ-032 SHALL use one combinational sub-module, hex_ascii, mapping a 4-bit nibble to `0`-`9`/`a`-`f`; it is instantiated once on the selected nibble.

Verification
REQ-033 SHALL pass: macro off; kind 0, time 0x0012, pc 0x00003000, grf 5, data 0x0000abcd -> `^12@00003000:$5<=0000abcd#` over 26 cycles; in_ready low for the 24 cycles between `^` and `#`.
REQ-034 SHALL pass: macro off; kind 1, time 0x0000, pc 0x00003004, addr 0x00000ffc, data 0xdeadbeef -> `^0@00003004:*00000ffc<=deadbeef#`.
REQ-035 SHALL pass: macro on; kind 0, time 0x9999, pc 0x00004ffc, grf 31, data 0xffffffff -> `^9999@00004ffc: $31 <= ffffffff#`.
REQ-036 SHALL pass: two records with in_valid held high -> the second `^` appears in the cycle immediately after the first `#`, with no char_valid = 0 cycle between them.
REQ-037 SHALL pass: reset pulsed during the 10th character -> char_valid = 0 and in_ready = 1 the next cycle, and the following record starts cleanly with `^`.
REQ-038 SHALL pass: time 0x0A05 -> time field emitted as `X05`.

Source files
------------

// File: rtl/cpu_trace_pkg.sv
// cpu_trace_pkg: shared ASCII constants, record kind encoding and serializer state enum (SERIALIZER_SPACE_EN adds SP states)
package cpu_trace_pkg;
  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;
  localparam logic [7:0] CH_NUL   = 8'h00;
  localparam logic [7:0] CH_CARET = 8'h5e;
  localparam logic [7:0] CH_AT    = 8'h40;
  localparam logic [7:0] CH_COLON = 8'h3a;
  localparam logic [7:0] CH_DOLR  = 8'h24;
  localparam logic [7:0] CH_STAR  = 8'h2a;
  localparam logic [7:0] CH_LT    = 8'h3c;
  localparam logic [7:0] CH_EQ    = 8'h3d;
  localparam logic [7:0] CH_HASH  = 8'h23;
  localparam logic [7:0] CH_SP    = 8'h20;
  localparam logic [7:0] CH_X     = 8'h58;
  typedef enum logic [3:0] {
    S_IDLE, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_TAG, S_OPER, S_LT, S_EQ, S_DATA, S_HASH
`ifdef SERIALIZER_SPACE_EN
    , S_SP1, S_SP2, S_SP3
`endif
  } state_t;
endpackage

// File: rtl/hex_ascii.sv
// hex_ascii: maps a nibble to '0'-'9' / 'a'-'f'; ports i_nib (4b in), o_char (8b ASCII out)
module hex_ascii (
  input  logic [3:0] i_nib,
  output logic [7:0] o_char
);
  assign o_char = (i_nib < 4'd10) ? 8'h30 + {4'b0, i_nib} : 8'h57 + {4'b0, i_nib};
endmodule

// File: rtl/cpu_trace_serializer.sv
// cpu_trace_serializer: turns a register/memory write record into one ASCII trace line, a char per cycle; ports clk, reset, in_* record handshake, char_out/char_valid stream; SERIALIZER_SPACE_EN adds spaces around TAG/OPER and DATA
module cpu_trace_serializer
  import cpu_trace_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_kind,
  input  logic [15:0] in_time,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_grf,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_data,
  output logic [7:0]  char_out,
  output logic        char_valid
);
  state_t      r_state, w_next;
  logic [2:0]  r_cnt, w_sh;
  logic        r_kind, w_accept, w_dec2;
  logic [15:0] r_time;
  logic [31:0] r_pc, r_addr, r_data;
  logic [4:0]  r_grf;
  logic [1:0]  w_tstart, w_tidx, w_tens;
  logic [3:0]  w_ones, w_tnib, w_nib;
  logic [7:0]  w_hex;
  assign in_ready = (r_state == S_IDLE) || (r_state == S_HASH);
  assign w_accept = in_valid && in_ready;
  // first significant BCD digit; an all-zero time still shows its last digit
  assign w_tstart = |r_time[15:12] ? 2'd0 : |r_time[11:8] ? 2'd1 : |r_time[7:4] ? 2'd2 : 2'd3;
  assign w_tidx   = w_tstart + r_cnt[1:0];
  assign w_tnib   = r_time[{2'd3 - w_tidx, 2'b00} +: 4];
  assign w_tens   = r_grf >= 5'd30 ? 2'd3 : r_grf >= 5'd20 ? 2'd2 : r_grf >= 5'd10 ? 2'd1 : 2'd0;
  assign w_ones   = 4'(r_grf - 5'd10 * {3'b0, w_tens});
  assign w_dec2   = |w_tens;
  assign w_sh     = 3'd7 - r_cnt;
  always_comb
    w_nib = r_state == S_TIME ? w_tnib :
            r_state == S_PC   ? r_pc[{w_sh, 2'b00} +: 4] :
            r_state == S_DATA ? r_data[{w_sh, 2'b00} +: 4] :
            r_kind == KIND_MEM ? r_addr[{w_sh, 2'b00} +: 4] :
            (w_dec2 && r_cnt == 3'd0) ? {2'b00, w_tens} : w_ones;
  hex_ascii u_hex (.i_nib(w_nib), .o_char(w_hex));
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_accept ? S_CARET : S_IDLE;
      S_CARET: w_next = S_TIME;
      S_TIME:  w_next = (w_tidx == 2'd3) ? S_AT : S_TIME;
      S_AT:    w_next = S_PC;
      S_PC:    w_next = (r_cnt == 3'd7) ? S_COLON : S_PC;
`ifdef SERIALIZER_SPACE_EN
      S_COLON: w_next = S_SP1;
      S_SP1:   w_next = S_TAG;
      S_OPER:  w_next = (r_kind == KIND_MEM ? r_cnt == 3'd7 : (!w_dec2 || r_cnt == 3'd1)) ? S_SP2 : S_OPER;
      S_SP2:   w_next = S_LT;
      S_EQ:    w_next = S_SP3;
      S_SP3:   w_next = S_DATA;
`else
      S_COLON: w_next = S_TAG;
      S_OPER:  w_next = (r_kind == KIND_MEM ? r_cnt == 3'd7 : (!w_dec2 || r_cnt == 3'd1)) ? S_LT : S_OPER;
      S_EQ:    w_next = S_DATA;
`endif
      S_TAG:   w_next = S_OPER;
      S_LT:    w_next = S_EQ;
      S_DATA:  w_next = (r_cnt == 3'd7) ? S_HASH : S_DATA;
      S_HASH:  w_next = w_accept ? S_CARET : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end
  always_comb begin
    char_valid = r_state != S_IDLE;
    char_out   = CH_NUL;
    case (r_state)
      S_CARET: char_out = CH_CARET;
      S_TIME:  char_out = (w_tnib > 4'd9) ? CH_X : w_hex;
      S_AT:    char_out = CH_AT;
      S_COLON: char_out = CH_COLON;
      S_TAG:   char_out = (r_kind == KIND_MEM) ? CH_STAR : CH_DOLR;
      S_PC, S_OPER, S_DATA: char_out = w_hex;
      S_LT:    char_out = CH_LT;
      S_EQ:    char_out = CH_EQ;
      S_HASH:  char_out = CH_HASH;
`ifdef SERIALIZER_SPACE_EN
      S_SP1, S_SP2, S_SP3: char_out = CH_SP;
`endif
      default: char_out = CH_NUL;
    endcase
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_kind  <= 1'b0;
      r_time  <= 16'd0;
      r_pc    <= 32'd0;
      r_grf   <= 5'd0;
      r_addr  <= 32'd0;
      r_data  <= 32'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next == r_state && r_state != S_IDLE) ? r_cnt + 3'd1 : 3'd0;
      if (w_accept) begin
        r_kind <= in_kind;
        r_time <= in_time;
        r_pc   <= in_pc;
        r_grf  <= in_grf;
        r_addr <= in_addr;
        r_data <= in_data;
      end
    end
endmodule

// File: tb/tb_cpu_trace_serializer.sv
// tb_cpu_trace_serializer: directed scenario bench for cpu_trace_serializer
module tb_cpu_trace_serializer;
`ifdef SERIALIZER_SPACE_EN
  localparam bit SP = 1'b1;
`else
  localparam bit SP = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_kind = 1'b0;
  logic [15:0] in_time = '0;
  logic [31:0] in_pc = '0, in_addr = '0, in_data = '0;
  logic [4:0]  in_grf = '0;
  logic        in_ready, char_valid;
  logic [7:0]  char_out;
  int checks = 0, failures = 0;

  cpu_trace_serializer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_time(in_time), .in_pc(in_pc), .in_grf(in_grf), .in_addr(in_addr), .in_data(in_data),
    .char_out(char_out), .char_valid(char_valid)
  );

  always #5 clk = ~clk;

  function automatic string fmt(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (SP && s[i] == 8'h3c) r = {r, " "};
      r = {r, s.substr(i, i)};
      if (SP && (s[i] == 8'h3a || s[i] == 8'h3d)) r = {r, " "};
    end
    return r;
  endfunction

  task automatic set_rec(input logic k, input logic [15:0] t, input logic [31:0] pc,
                         input logic [4:0] g, input logic [31:0] a, input logic [31:0] d);
    in_kind = k; in_time = t; in_pc = pc; in_grf = g; in_addr = a; in_data = d;
  endtask

  task automatic run_line(input logic k, input logic [15:0] t, input logic [31:0] pc,
                          input logic [4:0] g, input logic [31:0] a, input logic [31:0] d,
                          output string s, output int gaps, output int rlow, output logic rhash,
                          output logic tout);
    s = ""; gaps = 0; rlow = 0; rhash = 1'b0; tout = 1'b1;
    @(negedge clk);
    in_valid = 1'b1;
    set_rec(k, t, pc, g, a, d);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (!char_valid) gaps++;
      else begin
        s = $sformatf("%s%c", s, char_out);
        if (char_out == 8'h23) begin
          rhash = in_ready;
          tout = 1'b0;
          break;
        end
        if (s.len() > 1 && !in_ready) rlow++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    in_valid = 1'b1;
    set_rec(1'b0, 16'h0001, 32'h1, 5'd1, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (char_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", char_valid); end
    checks++; if (char_out !== 8'h00) begin failures++; $display("FAIL reset_char got=%h exp=00", char_out); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    reset = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (char_valid !== 1'b0) begin failures++; $display("FAIL reset_priority got=%b exp=0", char_valid); end
  endtask

  task automatic test_reg_write;
    string s, e; int gaps, rlow; logic rh, to;
    e = fmt("^12@00003000:$5<=0000abcd#");
    run_line(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd, s, gaps, rlow, rh, to);
    checks++; if (s != e || to) begin failures++; $display("FAIL reg_line got=%s exp=%s", s, e); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL reg_gaps got=%0d exp=0", gaps); end
    checks++; if (rlow != e.len() - 2) begin failures++; $display("FAIL reg_ready_low got=%0d exp=%0d", rlow, e.len() - 2); end
    checks++; if (rh !== 1'b1) begin failures++; $display("FAIL reg_ready_hash got=%b exp=1", rh); end
  endtask

  task automatic test_mem_write;
    string s, e; int gaps, rlow; logic rh, to;
    e = fmt("^0@00003004:*00000ffc<=deadbeef#");
    run_line(1'b1, 16'h0000, 32'h00003004, 5'd0, 32'h00000ffc, 32'hdeadbeef, s, gaps, rlow, rh, to);
    checks++; if (s != e || to) begin failures++; $display("FAIL mem_line got=%s exp=%s", s, e); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL mem_gaps got=%0d exp=0", gaps); end
  endtask

  task automatic test_grf31;
    string s, e; int gaps, rlow; logic rh, to;
    e = fmt("^9999@00004ffc:$31<=ffffffff#");
    run_line(1'b0, 16'h9999, 32'h00004ffc, 5'd31, 32'h0, 32'hffffffff, s, gaps, rlow, rh, to);
    checks++; if (s != e || to) begin failures++; $display("FAIL grf31_line got=%s exp=%s", s, e); end
  endtask

  task automatic test_bad_bcd;
    string s, e; int gaps, rlow; logic rh, to;
    e = fmt("^X05@12345678:$0<=89abcdef#");
    run_line(1'b0, 16'h0a05, 32'h12345678, 5'd0, 32'h0, 32'h89abcdef, s, gaps, rlow, rh, to);
    checks++; if (s != e || to) begin failures++; $display("FAIL bad_bcd_line got=%s exp=%s", s, e); end
  endtask

  task automatic test_back_to_back;
    string s, e1, e; int gaps, hashes;
    s = ""; gaps = 0; hashes = 0;
    e1 = fmt("^1000@00000010:$10<=00000001#");
    e = {e1, fmt("^100@fffffffc:*80000000<=00000000#")};
    @(negedge clk);
    in_valid = 1'b1;
    set_rec(1'b0, 16'h1000, 32'h00000010, 5'd10, 32'h0, 32'h00000001);
    @(negedge clk);
    set_rec(1'b1, 16'h0100, 32'hfffffffc, 5'd0, 32'h80000000, 32'h0);
    for (int i = 0; i < 120 && hashes < 2; i++) begin
      if (!char_valid) gaps++;
      else begin
        s = $sformatf("%s%c", s, char_out);
        if (s.len() == e1.len() + 1) in_valid = 1'b0;
        if (char_out == 8'h23) hashes++;
      end
      if (hashes < 2) @(negedge clk);
    end
    in_valid = 1'b0;
    checks++; if (s != e) begin failures++; $display("FAIL b2b_lines got=%s exp=%s", s, e); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
    @(negedge clk);
    checks++; if (char_valid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b exp=0", char_valid); end
  endtask

  task automatic test_reset_mid;
    string s, e; int n, resumed, gaps, rlow; logic rh, to;
    n = 0; resumed = 0;
    @(negedge clk);
    in_valid = 1'b1;
    set_rec(1'b0, 16'h0012, 32'h00003000, 5'd5, 32'h0, 32'h0000abcd);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      if (char_valid) n++;
      if (n < 10) @(negedge clk);
    end
    checks++; if (n != 10) begin failures++; $display("FAIL mid_reach10 got=%0d exp=10", n); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (char_valid !== 1'b0) begin failures++; $display("FAIL mid_valid got=%b exp=0", char_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (char_valid) resumed++;
    end
    checks++; if (resumed != 0) begin failures++; $display("FAIL mid_resumed got=%0d exp=0", resumed); end
    e = fmt("^0@00003004:*00000ffc<=deadbeef#");
    run_line(1'b1, 16'h0000, 32'h00003004, 5'd0, 32'h00000ffc, 32'hdeadbeef, s, gaps, rlow, rh, to);
    checks++; if (s != e || to) begin failures++; $display("FAIL mid_next_line got=%s exp=%s", s, e); end
  endtask

  initial begin
    test_reset;
    test_reg_write;
    test_mem_write;
    test_grf31;
    test_bad_bcd;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
